// File: rtl/riscv_data_mem.sv
// Word-addressed data memory for the LSU: one request at a time, fixed LATENCY
// from acceptance to a one-cycle ready pulse, with byte-lane writes.
module riscv_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_to_resp;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_we;
  logic          w_unused_addr;

  // Byte offset and bits above the array wrap are deliberately dropped.
  assign w_idx         = mem_addr_i[2 +: AW];
  assign w_unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};

  // Gated by rst_i so no write can slip into the array while reset is held.
  assign w_accept  = rst_i && (r_state == StIdle) && mem_req_i;
  assign w_to_resp = (w_accept && (LATENCY == 1)) || ((r_state == StBusy) && (r_cnt == 4'd1));
  // With LATENCY=1 the response edge is also the acceptance edge, so use live inputs.
  assign w_rd_idx  = (r_state == StIdle) ? w_idx : r_idx;
  assign w_rd_we   = (r_state == StIdle) ? mem_we_i : r_we;

  assign mem_ready_o = (r_state == StResp);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      mem_rd_o <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (mem_req_i) begin
            r_we  <= mem_we_i;
            r_idx <= w_idx;
            if (LATENCY == 1) begin
              r_state <= StResp;
            end else begin
              r_state <= StBusy;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= StResp;
        end
        StResp:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      if (w_to_resp && !w_rd_we) mem_rd_o <= r_mem[w_rd_idx];
    end
  end

  // Writes commit at acceptance; byte enables and data need no capture beyond this edge.
  always_ff @(posedge clk_i) begin
    if (w_accept && mem_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_i[b]) r_mem[w_idx][8*b +: 8] <= mem_wd_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: three instances (LATENCY 2, 1, 4) driven from
// a vector table plus hand sequences for back-to-back, dropped-request and reset cases.
module tb_riscv_data_mem;

  logic        clk;
  logic        rst_n [3];
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rd    [3];
  logic        rdy   [3];

  int n_checks = 0;
  int n_errors = 0;

  riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst_n[0]), .mem_req_i(req[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
    .mem_addr_i(addr[0]), .mem_wd_i(wd[0]), .mem_rd_o(rd[0]), .mem_ready_o(rdy[0])
  );
  riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst_n[1]), .mem_req_i(req[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
    .mem_addr_i(addr[1]), .mem_wd_i(wd[1]), .mem_rd_o(rd[1]), .mem_ready_o(rdy[1])
  );
  riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_i(rst_n[2]), .mem_req_i(req[2]), .mem_we_i(we[2]), .mem_be_i(be[2]),
    .mem_addr_i(addr[2]), .mem_wd_i(wd[2]), .mem_rd_o(rd[2]), .mem_ready_o(rdy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.inst = i; v.we = w; v.be = b; v.addr = a; v.wd = d; v.exp_rd = e;
    tbl.push_back(v);
  endtask

  // One full transaction: checks ready latency, read data and single-cycle pulse.
  task automatic do_txn(input int i, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    int k;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wd[i] = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy[i] && k < 20);
    req[i] = 1'b0;
    chk({name, " latency"}, 32'(k), 32'(lat_of(i)));
    chk({name, " rd"}, rd[i], exp_rd);
    @(negedge clk);
    chk({name, " pulse width"}, {31'd0, rdy[i]}, 32'd0);
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = '0; wd[i] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset rdy%0d", i), {31'd0, rdy[i]}, 32'd0);
      chk($sformatf("reset rd%0d", i), rd[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    add(0, 1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0);
    add(0, 0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF);
    add(0, 1, 4'hF, 32'h20,   32'h11223344, 32'hDEADBEEF);
    add(0, 1, 4'h4, 32'h20,   32'hAAAAAAAA, 32'hDEADBEEF);
    add(0, 0, 4'hF, 32'h20,   32'h0,        32'h11AA3344);
    add(0, 1, 4'hF, 32'h1000, 32'h00000005, 32'h11AA3344);
    add(0, 0, 4'hF, 32'h0,    32'h0,        32'h00000005);
    add(0, 0, 4'hF, 32'h13,   32'h0,        32'hDEADBEEF);
    add(0, 1, 4'hF, 32'h24,   32'h01020304, 32'hDEADBEEF);
    add(0, 1, 4'h9, 32'h24,   32'hA5B6C7D8, 32'hDEADBEEF);
    add(0, 0, 4'hF, 32'h24,   32'h0,        32'hA50203D8);
    add(0, 0, 4'hF, 32'h1010, 32'h0,        32'hDEADBEEF);
    add(1, 1, 4'hF, 32'h0,    32'h0BADF00D, 32'h0);
    add(1, 1, 4'hF, 32'h4,    32'h12345678, 32'h0);
    add(1, 0, 4'hF, 32'h4,    32'h0,        32'h12345678);
    add(2, 1, 4'hF, 32'h8,    32'hCAFEBABE, 32'h0);
    add(2, 1, 4'hF, 32'hC,    32'h13579BDF, 32'h0);
    add(2, 0, 4'hF, 32'h8,    32'h0,        32'hCAFEBABE);

    foreach (tbl[n]) begin
      do_txn(tbl[n].inst, tbl[n].we, tbl[n].be, tbl[n].addr, tbl[n].wd, tbl[n].exp_rd,
             $sformatf("vec%0d", n));
    end

    // LATENCY=1 back-to-back reads with req held: ready in T+1 and T+3.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    @(negedge clk);
    chk("b2b rdy T+1", {31'd0, rdy[1]}, 32'd1);
    chk("b2b rd T+1", rd[1], 32'h0BADF00D);
    addr[1] = 32'h4;
    @(negedge clk);
    chk("b2b rdy T+2", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    chk("b2b rdy T+3", {31'd0, rdy[1]}, 32'd1);
    chk("b2b rd T+3", rd[1], 32'h12345678);
    req[1] = 1'b0;
    @(negedge clk);
    chk("b2b rdy T+4", {31'd0, rdy[1]}, 32'd0);

    // Request dropped during BUSY still completes.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h20;
    @(negedge clk);
    req[0] = 1'b0;
    chk("drop rdy T+1", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("drop rdy T+2", {31'd0, rdy[0]}, 32'd1);
    chk("drop rd", rd[0], 32'h11AA3344);
    @(negedge clk);
    chk("drop rdy T+3", {31'd0, rdy[0]}, 32'd0);
    do_txn(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h11AA3344, "be0 write");
    do_txn(0, 0, 4'hF, 32'h20, 32'h0,        32'h11AA3344, "be0 readback");

    // Inputs changed while BUSY must not alter the captured request.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h8; wd[2] = 32'h0;
    @(negedge clk);
    addr[2] = 32'hC; we[2] = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (rdy[2]) pulses++;
    end
    chk("busy ignore early rdy", 32'(pulses), 32'd0);
    @(negedge clk);
    chk("busy ignore rdy T+4", {31'd0, rdy[2]}, 32'd1);
    chk("busy ignore rd", rd[2], 32'hCAFEBABE);
    req[2] = 1'b0; we[2] = 1'b0;
    do_txn(2, 0, 4'hF, 32'hC, 32'h0, 32'h13579BDF, "busy ignore no write");

    // Reset in cycle T+2 of a LATENCY=4 read abandons it.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0;
    req[2] = 1'b0;
    #1;
    chk("midrst rdy", {31'd0, rdy[2]}, 32'd0);
    chk("midrst rd", rd[2], 32'h0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2]) pulses++;
    end
    chk("midrst no ready", 32'(pulses), 32'd0);
    chk("midrst rd held", rd[2], 32'h0);
    do_txn(2, 0, 4'hF, 32'h8, 32'h0, 32'hCAFEBABE, "post reset read");

    // A write accepted before reset stays committed.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'hC; wd[2] = 32'h77777777;
    @(negedge clk);
    rst_n[2] = 1'b0;
    req[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    do_txn(2, 0, 4'hF, 32'hC, 32'h0, 32'h77777777, "committed write");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
